// File: rtl/adc_osr_receiver_if.sv
// rtl/adc_osr_receiver_if.sv - frame-sum output stream between the OSR receiver and its consumer
interface adc_osr_receiver_if #(
  parameter int ACC_BITS = 20
);
  logic [ACC_BITS-1:0] data_out;
  logic                data_valid_out;
  logic                data_ready_in;

  modport master (
    output data_out,
    output data_valid_out,
    input  data_ready_in
  );

  modport slave (
    input  data_out,
    input  data_valid_out,
    output data_ready_in
  );
endinterface

// File: rtl/adc_osr_receiver.sv
// rtl/adc_osr_receiver.sv - sums 1/4/16/64/256 SAR results per frame; optional OSR_SKIP_FIRST_EN drops first sample after reset
module adc_osr_receiver #(
  parameter int RESULT_BITS = 12,
  parameter int ACC_BITS    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RESULT_BITS-1:0] result_in,
  input  logic                   conv_finished_strobe_in,
  input  logic [2:0]             osr_mode_in,
  adc_osr_receiver_if.master     out_if,
  output logic                   overrun_out
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state;
  logic                strobe_q;
  logic [2:0]          mode_q;
  logic [8:0]          cnt;
  logic [ACC_BITS-1:0] acc;
  logic                accept;
  logic                skip;
  logic                take;
  logic                last;
  logic [8:0]          frame_n;
  logic [ACC_BITS-1:0] sum;

  function automatic logic [8:0] frame_len(input logic [2:0] m);
    case (m)
      3'd1:    frame_len = 9'd4;
      3'd2:    frame_len = 9'd16;
      3'd3:    frame_len = 9'd64;
      3'd4:    frame_len = 9'd256;
      default: frame_len = 9'd1;
    endcase
  endfunction

  assign accept = conv_finished_strobe_in & ~strobe_q;

`ifdef OSR_SKIP_FIRST_EN
  logic skip_done;
  assign skip = ~skip_done;
`else
  assign skip = 1'b0;
`endif

  assign take = accept & ~skip;

  // The first sample of a frame uses the live mode; later samples use the latched one.
  always_comb begin
    frame_n = frame_len((state == IDLE) ? osr_mode_in : mode_q);
    sum     = ((state == IDLE) ? '0 : acc) + {{(ACC_BITS-RESULT_BITS){1'b0}}, result_in};
    last    = ((cnt + 9'd1) == frame_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      strobe_q              <= 1'b1;
      mode_q                <= 3'd0;
      cnt                   <= 9'd0;
      acc                   <= '0;
      out_if.data_out       <= '0;
      out_if.data_valid_out <= 1'b0;
      overrun_out           <= 1'b0;
`ifdef OSR_SKIP_FIRST_EN
      skip_done             <= 1'b0;
`endif
    end else begin
      strobe_q <= conv_finished_strobe_in;
`ifdef OSR_SKIP_FIRST_EN
      if (accept) skip_done <= 1'b1;
`endif
      if (take) begin
        if (state == IDLE) mode_q <= osr_mode_in;
        if (last) begin
          acc   <= '0;
          cnt   <= 9'd0;
          state <= IDLE;
        end else begin
          acc   <= sum;
          cnt   <= cnt + 9'd1;
          state <= ACCUM;
        end
      end

      // A completing frame wins over a handshake; overwriting unread data is an overrun.
      if (take && last) begin
        out_if.data_out       <= sum;
        out_if.data_valid_out <= 1'b1;
        if (out_if.data_valid_out && !out_if.data_ready_in) overrun_out <= 1'b1;
      end else if (out_if.data_valid_out && out_if.data_ready_in) begin
        out_if.data_valid_out <= 1'b0;
      end
    end
  end

endmodule
